// File: rtl/rgb_frame_loader_pkg.sv
// Shared definitions for the RGB frame loader: FSM encoding, frame geometry,
// colour byte offsets and the timeout counter width.
package rgb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  localparam int NUM_LEDS        = 8;
  localparam int BYTES_PER_LED   = 3;
  localparam int BYTES_PER_FRAME = NUM_LEDS * BYTES_PER_LED;

  localparam int OFS_R = 0;
  localparam int OFS_G = 1;
  localparam int OFS_B = 2;

  localparam int TMO_W = 16;
  localparam int PTR_W = 5;

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(BYTES_PER_FRAME - 1);

  // Flat shadow/active index of one colour byte of one LED (led counted from 0).
  function automatic logic [PTR_W-1:0] led_byte_idx(input int led, input int ofs);
    return PTR_W'(led * BYTES_PER_LED + ofs);
  endfunction

endpackage

// File: rtl/rgb_frame_loader_if.sv
// Write-side bus of the RGB frame loader, driven by the SPI/UART receive stage.
interface rgb_frame_loader_if;
  // All four signals are single-cycle strobes sampled on the rising clock edge.
  // There is no ready/back-pressure: the loader accepts or deliberately drops
  // every strobe in the cycle it is presented, so the producer never waits.
  logic       WR_FRAME;
  logic       WR_VALID;
  logic [7:0] WR_DATA;
  logic       COMMIT;

  modport master (
    output WR_FRAME,
    output WR_VALID,
    output WR_DATA,
    output COMMIT
  );

  modport slave (
    input WR_FRAME,
    input WR_VALID,
    input WR_DATA,
    input COMMIT
  );
endinterface

// File: rtl/rgb_frame_loader_scale.sv
// One colour channel of global brightness: (byte * (bright + 1)) >> 8, registered.
// Only instantiated when RGB_BRIGHTNESS_EN is defined.
module rgb_scale (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] i_byte,
  input  logic [7:0] i_bright,
  output logic [7:0] o_byte
);
  logic [15:0] w_prod;
  logic [8:0]  w_gain;
  logic [7:0]  r_byte;

  // Gain of bright+1 lets 255 be an exact pass-through.
  assign w_gain = {1'b0, i_bright} + 9'd1;
  assign w_prod = 16'({8'd0, i_byte} * {7'd0, w_gain});

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_byte <= 8'd0;
    end else begin
      r_byte <= w_prod[15:8];
    end
  end

  assign o_byte = r_byte;
endmodule

// File: rtl/rgb_frame_loader.sv
// Loads a 24-byte colour frame into a shadow buffer and publishes it atomically
// on COMMIT to the 8-LED driver inputs. Optional feature macro: RGB_BRIGHTNESS_EN.
module rgb_frame_loader
  import rgb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  rgb_frame_loader_if.slave wr,
`ifdef RGB_BRIGHTNESS_EN
  input  logic [7:0] BRIGHT,
`endif
  output logic [7:0] D1_R,
  output logic [7:0] D1_G,
  output logic [7:0] D1_B,
  output logic [7:0] D2_R,
  output logic [7:0] D2_G,
  output logic [7:0] D2_B,
  output logic [7:0] D3_R,
  output logic [7:0] D3_G,
  output logic [7:0] D3_B,
  output logic [7:0] D4_R,
  output logic [7:0] D4_G,
  output logic [7:0] D4_B,
  output logic [7:0] D5_R,
  output logic [7:0] D5_G,
  output logic [7:0] D5_B,
  output logic [7:0] D6_R,
  output logic [7:0] D6_G,
  output logic [7:0] D6_B,
  output logic [7:0] D7_R,
  output logic [7:0] D7_G,
  output logic [7:0] D7_B,
  output logic [7:0] D8_R,
  output logic [7:0] D8_G,
  output logic [7:0] D8_B,
  output logic       FRAME_FULL,
  output logic       FRAME_ERR,
  output state_t     o_dbg_state
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [TMO_W-1:0]  r_tmo;
  logic [TMO_W-1:0]  w_tmo_nxt;
  logic              r_err;
  logic              w_err_set;
  logic              w_wr_en;
  logic [PTR_W-1:0]  w_wr_idx;
  logic              w_commit;

  logic [7:0] r_shadow [BYTES_PER_FRAME];
  logic [7:0] r_active [BYTES_PER_FRAME];
  logic [7:0] w_out    [BYTES_PER_FRAME];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_tmo_nxt   = r_tmo;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_ptr;
    w_err_set   = 1'b0;
    // Commit reads the current shadow before any same-cycle restart touches it.
    w_commit    = (r_state == ST_FULL) && wr.COMMIT;

    if ((r_state == ST_LOAD) && wr.COMMIT) begin
      w_err_set = 1'b1;
    end

    if (wr.WR_FRAME) begin
      w_state_nxt = ST_LOAD;
      w_tmo_nxt   = '0;
      if (wr.WR_VALID) begin
        w_wr_en   = 1'b1;
        w_wr_idx  = '0;
        w_ptr_nxt = PTR_W'(1);
      end else begin
        w_ptr_nxt = '0;
      end
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (wr.WR_VALID) begin
            w_wr_en   = 1'b1;
            w_tmo_nxt = '0;
            if (r_ptr == LAST_IDX) begin
              w_state_nxt = ST_FULL;
              w_ptr_nxt   = '0;
            end else begin
              w_ptr_nxt = r_ptr + PTR_W'(1);
            end
          end else if (r_tmo == TMO_LAST) begin
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = '0;
            w_tmo_nxt   = '0;
            w_err_set   = 1'b1;
          end else begin
            w_tmo_nxt = r_tmo + TMO_W'(1);
          end
        end
        ST_FULL: begin
          if (wr.WR_VALID) begin
            w_err_set = 1'b1;
          end
          if (wr.COMMIT) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (wr.WR_FRAME) begin
      r_err <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < BYTES_PER_FRAME; i++) begin
        r_shadow[i] <= 8'd0;
      end
    end else if (w_wr_en) begin
      r_shadow[w_wr_idx] <= wr.WR_DATA;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < BYTES_PER_FRAME; i++) begin
        r_active[i] <= 8'd0;
      end
    end else if (w_commit) begin
      for (int i = 0; i < BYTES_PER_FRAME; i++) begin
        r_active[i] <= r_shadow[i];
      end
    end
  end

  for (genvar g = 0; g < BYTES_PER_FRAME; g++) begin : g_out
`ifdef RGB_BRIGHTNESS_EN
    rgb_scale u_scale (
      .CLK      (CLK),
      .RST      (RST),
      .i_byte   (r_active[g]),
      .i_bright (BRIGHT),
      .o_byte   (w_out[g])
    );
`else
    assign w_out[g] = r_active[g];
`endif
  end

  assign D1_R = w_out[led_byte_idx(0, OFS_R)];
  assign D1_G = w_out[led_byte_idx(0, OFS_G)];
  assign D1_B = w_out[led_byte_idx(0, OFS_B)];
  assign D2_R = w_out[led_byte_idx(1, OFS_R)];
  assign D2_G = w_out[led_byte_idx(1, OFS_G)];
  assign D2_B = w_out[led_byte_idx(1, OFS_B)];
  assign D3_R = w_out[led_byte_idx(2, OFS_R)];
  assign D3_G = w_out[led_byte_idx(2, OFS_G)];
  assign D3_B = w_out[led_byte_idx(2, OFS_B)];
  assign D4_R = w_out[led_byte_idx(3, OFS_R)];
  assign D4_G = w_out[led_byte_idx(3, OFS_G)];
  assign D4_B = w_out[led_byte_idx(3, OFS_B)];
  assign D5_R = w_out[led_byte_idx(4, OFS_R)];
  assign D5_G = w_out[led_byte_idx(4, OFS_G)];
  assign D5_B = w_out[led_byte_idx(4, OFS_B)];
  assign D6_R = w_out[led_byte_idx(5, OFS_R)];
  assign D6_G = w_out[led_byte_idx(5, OFS_G)];
  assign D6_B = w_out[led_byte_idx(5, OFS_B)];
  assign D7_R = w_out[led_byte_idx(6, OFS_R)];
  assign D7_G = w_out[led_byte_idx(6, OFS_G)];
  assign D7_B = w_out[led_byte_idx(6, OFS_B)];
  assign D8_R = w_out[led_byte_idx(7, OFS_R)];
  assign D8_G = w_out[led_byte_idx(7, OFS_G)];
  assign D8_B = w_out[led_byte_idx(7, OFS_B)];

  assign FRAME_FULL  = (r_state == ST_FULL);
  assign FRAME_ERR   = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rgb_frame_loader.sv
// Directed self-checking bench for rgb_frame_loader (default build; brightness
// checks added when RGB_BRIGHTNESS_EN is defined).
module tb_rgb_frame_loader;
  import rgb_pkg::*;

  logic clk;
  logic rst;
  logic [7:0] bright;
  logic [7:0] d_obs [24];
  logic frame_full;
  logic frame_err;
  state_t dbg_state;

  logic [7:0] exp_q [$];
  int n_checks;
  int n_fail;

  rgb_frame_loader_if wr_if ();

  rgb_frame_loader dut (
    .CLK         (clk),
    .RST         (rst),
    .wr          (wr_if),
`ifdef RGB_BRIGHTNESS_EN
    .BRIGHT      (bright),
`endif
    .D1_R (d_obs[0]),  .D1_G (d_obs[1]),  .D1_B (d_obs[2]),
    .D2_R (d_obs[3]),  .D2_G (d_obs[4]),  .D2_B (d_obs[5]),
    .D3_R (d_obs[6]),  .D3_G (d_obs[7]),  .D3_B (d_obs[8]),
    .D4_R (d_obs[9]),  .D4_G (d_obs[10]), .D4_B (d_obs[11]),
    .D5_R (d_obs[12]), .D5_G (d_obs[13]), .D5_B (d_obs[14]),
    .D6_R (d_obs[15]), .D6_G (d_obs[16]), .D6_B (d_obs[17]),
    .D7_R (d_obs[18]), .D7_G (d_obs[19]), .D7_B (d_obs[20]),
    .D8_R (d_obs[21]), .D8_G (d_obs[22]), .D8_B (d_obs[23]),
    .FRAME_FULL  (frame_full),
    .FRAME_ERR   (frame_err),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Extra cycle for the registered brightness stage when it is built in.
  task automatic settle();
`ifdef RGB_BRIGHTNESS_EN
    tick();
`endif
  endtask

  task automatic frame_start();
    wr_if.WR_FRAME = 1'b1;
    tick();
    wr_if.WR_FRAME = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    wr_if.WR_VALID = 1'b1;
    wr_if.WR_DATA  = b;
    tick();
    wr_if.WR_VALID = 1'b0;
  endtask

  task automatic commit();
    wr_if.COMMIT = 1'b1;
    tick();
    wr_if.COMMIT = 1'b0;
    settle();
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_fill_const(input logic [7:0] v);
    for (int i = 0; i < 24; i++) exp_q.push_back(v);
  endtask

  task automatic exp_fill_ramp(input logic [7:0] first);
    for (int i = 0; i < 24; i++) exp_q.push_back(8'(first + 8'(i)));
  endtask

  task automatic check_frame(input string tag);
    for (int i = 0; i < 24; i++) begin
      check_eq($sformatf("%s_d%0d", tag, i), {24'd0, d_obs[i]}, {24'd0, exp_q.pop_front()});
    end
  endtask

  task automatic check_flags(input string tag, input logic full, input logic err, input state_t st);
    check_eq({tag, "_full"}, {31'd0, frame_full}, {31'd0, full});
    check_eq({tag, "_err"}, {31'd0, frame_err}, {31'd0, err});
    check_eq({tag, "_state"}, {30'd0, dbg_state}, {30'd0, st});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    bright   = 8'hFF;
    wr_if.WR_FRAME = 1'b0;
    wr_if.WR_VALID = 1'b0;
    wr_if.WR_DATA  = 8'h00;
    wr_if.COMMIT   = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    exp_fill_const(8'h00);
    check_frame("reset");
    check_flags("reset", 1'b0, 1'b0, ST_IDLE);
    rst = 1'b0;
    tick();

    // Basic load 0x01..0x18
    frame_start();
    for (int i = 1; i <= 23; i++) send_byte(8'(i));
    check_flags("basic_23", 1'b0, 1'b0, ST_LOAD);
    send_byte(8'h18);
    check_flags("basic_24", 1'b1, 1'b0, ST_FULL);
    check_eq("basic_precommit_d1r", {24'd0, d_obs[0]}, 32'h0);
    commit();
    exp_fill_ramp(8'h01);
    check_frame("basic");
    check_flags("basic_post", 1'b0, 1'b0, ST_IDLE);

    // Atomicity: committed 0x11 survives a partial 0x22 frame
    frame_start();
    repeat (24) send_byte(8'h11);
    commit();
    frame_start();
    repeat (12) send_byte(8'h22);
    exp_fill_const(8'h11);
    check_frame("atomic");
    check_flags("atomic", 1'b0, 1'b0, ST_LOAD);

    // Overflow: restart mid-LOAD, 25 bytes, commit publishes first 24
    frame_start();
    check_flags("restart", 1'b0, 1'b0, ST_LOAD);
    for (int i = 0; i < 25; i++) send_byte(8'(8'h30 + 8'(i)));
    check_flags("ovf", 1'b1, 1'b1, ST_FULL);
    commit();
    exp_fill_ramp(8'h30);
    check_frame("ovf");
    check_flags("ovf_post", 1'b0, 1'b1, ST_IDLE);

    // Early commit in LOAD
    frame_start();
    check_eq("err_clr", {31'd0, frame_err}, 32'd0);
    repeat (10) send_byte(8'h55);
    commit();
    exp_fill_ramp(8'h30);
    check_frame("early");
    check_flags("early", 1'b0, 1'b1, ST_LOAD);

    // Timeout boundary: 49999 idle cycles still LOAD, 50000th aborts
    frame_start();
    repeat (5) send_byte(8'h77);
    repeat (49999) tick();
    check_flags("tmo_edge", 1'b0, 1'b0, ST_LOAD);
    tick();
    check_flags("tmo", 1'b0, 1'b1, ST_IDLE);
    repeat (24) send_byte(8'h99);
    check_flags("tmo_ign", 1'b0, 1'b1, ST_IDLE);
    commit();
    exp_fill_ramp(8'h30);
    check_frame("tmo");

    // WR_FRAME + WR_VALID together stores byte 0
    wr_if.WR_FRAME = 1'b1;
    send_byte(8'hAA);
    wr_if.WR_FRAME = 1'b0;
    for (int i = 1; i <= 23; i++) send_byte(8'(i));
    check_flags("simul", 1'b1, 1'b0, ST_FULL);
    commit();
    check_eq("simul_d1r", {24'd0, d_obs[0]}, 32'hAA);
    check_eq("simul_d1g", {24'd0, d_obs[1]}, 32'h01);
    check_eq("simul_d8b", {24'd0, d_obs[23]}, 32'h17);

    // COMMIT + WR_FRAME together in FULL: publish, then LOAD
    frame_start();
    for (int i = 0; i < 24; i++) send_byte(8'(8'h60 + 8'(i)));
    wr_if.WR_FRAME = 1'b1;
    commit();
    wr_if.WR_FRAME = 1'b0;
    exp_fill_ramp(8'h60);
    check_frame("cmt_frm");
    check_flags("cmt_frm", 1'b0, 1'b0, ST_LOAD);

    // WR_FRAME in FULL without COMMIT discards the frame
    repeat (24) send_byte(8'h77);
    frame_start();
    check_flags("discard", 1'b0, 1'b0, ST_LOAD);
    exp_fill_ramp(8'h60);
    check_frame("discard");

    // Async reset during byte 13
    wr_if.COMMIT = 1'b1;
    tick();
    wr_if.COMMIT = 1'b0;
    repeat (12) send_byte(8'h44);
    check_eq("pre_rst_err", {31'd0, frame_err}, 32'd1);
    wr_if.WR_VALID = 1'b1;
    wr_if.WR_DATA  = 8'h44;
    #2 rst = 1'b1;
    #1;
    exp_fill_const(8'h00);
    check_frame("rst");
    check_flags("rst", 1'b0, 1'b0, ST_IDLE);
    wr_if.WR_VALID = 1'b0;
    #2 rst = 1'b0;
    tick();

`ifdef RGB_BRIGHTNESS_EN
    frame_start();
    repeat (24) send_byte(8'hFF);
    commit();
    check_eq("br_ff", {24'd0, d_obs[0]}, 32'hFF);
    bright = 8'h7F;
    tick();
    check_eq("br_7f", {24'd0, d_obs[0]}, 32'h7F);
    bright = 8'h00;
    tick();
    check_eq("br_00", {24'd0, d_obs[23]}, 32'h00);
    bright = 8'hFF;
    tick();
    check_eq("br_back", {24'd0, d_obs[5]}, 32'hFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
